// File: rtl/data_memory_if.sv
// Load/store bus between the MEM stage and the data memory.
interface data_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  WR_RD;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  ready;

  modport master (output address, WR_RD, dataIn, input dataOut, ready);
  modport slave  (input address, WR_RD, dataIn, output dataOut, ready);
endinterface

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, combinational read,
// and a reset-triggered sweep that zeroes every word before accepting accesses.
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic          clk,
  input  logic          rst,
  data_memory_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, READY} state_t;

  // Power-up contents and state; reset replaces this with an explicit sweep.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  state_t                state = READY;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr = '0;
  logic                  wr_en;

  // X on WR_RD makes the compare unknown, so the if below skips the write.
  assign wr_en = (state == READY) && (bus.WR_RD == 1'b0);

  always_ff @(posedge clk) begin
    if (rst) state <= CLEAR;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_ptr == '1) state_next = READY;
      READY:   state_next = READY;
      default: state_next = CLEAR;
    endcase
  end

  always_comb begin
    bus.ready   = 1'b0;
    bus.dataOut = '0;
    if (state == READY) begin
      bus.ready   = 1'b1;
      bus.dataOut = mem[bus.address];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 clr_ptr <= '0;
    else if (state == CLEAR) clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
  end

  // Reset wins over a coincident write; the sweep owns the array while clearing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr]     <= '0;
      else if (wr_en)     mem[bus.address] <= bus.dataIn;
    end
  end
endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory against an array reference model.
module tb_data_memory;
  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.address = a;
    bus.WR_RD   = 1'b0;
    bus.dataIn  = d;
    step();
    ref_mem[a]  = d;
    bus.WR_RD   = 1'b1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic test_powerup();
    bus.WR_RD = 1'b1;
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL powerup_ready got=%b exp=1", bus.ready);
    end
    for (int a = 0; a < 10; a++) begin
      bus.address = AW'(a);
      #1;
      checks++;
      if (bus.dataOut !== ref_mem[a]) begin
        failures++;
        $display("FAIL powerup_read addr=%0d got=%0d exp=%0d", a, bus.dataOut, ref_mem[a]);
      end
      step();
    end
  endtask

  task automatic test_write_burst();
    logic [DW-1:0] exp_vals [6];
    exp_vals = '{32'd315, 32'd945, 32'd2835, 32'd8505, 32'd0, 32'd0};
    do_write(10'd0, 32'd105);
    do_write(10'd0, 32'd315);
    do_write(10'd1, 32'd945);
    do_write(10'd2, 32'd2835);
    do_write(10'd3, 32'd8505);
    for (int a = 0; a < 6; a++) begin
      bus.address = AW'(a);
      #1;
      checks++;
      if (bus.dataOut !== exp_vals[a] || bus.dataOut !== ref_mem[a]) begin
        failures++;
        $display("FAIL burst_read addr=%0d got=%0d exp=%0d", a, bus.dataOut, exp_vals[a]);
      end
    end
    step();
  endtask

  task automatic test_async_read();
    logic [AW-1:0] a;
    for (int i = 0; i < 8; i++) begin
      a = AW'($urandom_range(0, 15));
      do_write(a, $urandom);
    end
    // several address changes inside one clock phase, no edge between them
    for (int i = 0; i < 4; i++) begin
      a = AW'($urandom_range(0, 15));
      bus.address = a;
      #1;
      checks++;
      if (bus.dataOut !== ref_mem[a]) begin
        failures++;
        $display("FAIL async_read addr=%0d got=%h exp=%h", a, bus.dataOut, ref_mem[a]);
      end
    end
    step();
  endtask

  task automatic test_random_traffic();
    logic [AW-1:0] a;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, $urandom);
        bus.address = a;
        #1;
        checks++;
        if (bus.dataOut !== ref_mem[a]) begin
          failures++;
          $display("FAIL write_then_read addr=%0d got=%h exp=%h", a, bus.dataOut, ref_mem[a]);
        end
      end else begin
        bus.address = a;
        #1;
        checks++;
        if (bus.dataOut !== ref_mem[a]) begin
          failures++;
          $display("FAIL random_read addr=%0d got=%h exp=%h", a, bus.dataOut, ref_mem[a]);
        end
        step();
      end
    end
  endtask

  // Expects the reset edge to have just passed; checks the full sweep window.
  task automatic check_sweep(input string name);
    for (int c = 0; c < DEPTH; c++) begin
      bus.address = 10'd1023;
      bus.WR_RD   = 1'b0;
      bus.dataIn  = $urandom | 32'h1;
      #1;
      checks++;
      if (bus.ready !== 1'b0 || bus.dataOut !== '0) begin
        failures++;
        $display("FAIL %s_busy cycle=%0d ready=%b dataOut=%h exp ready=0 dataOut=0",
                 name, c, bus.ready, bus.dataOut);
      end
      step();
    end
    bus.WR_RD = 1'b1;
    clear_model();
    #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_after got=%b exp=1", name, bus.ready);
    end
  endtask

  task automatic test_reset_clear();
    do_write(10'd1023, 32'h0000_00A5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_sweep("reset_clear");
    for (int a = 0; a < 4; a++) begin
      bus.address = AW'(a);
      #1;
      checks++;
      if (bus.dataOut !== '0) begin
        failures++;
        $display("FAIL reset_clear_read addr=%0d got=%h exp=0", a, bus.dataOut);
      end
    end
    bus.address = 10'd1023;
    #1;
    checks++;
    if (bus.dataOut !== ref_mem[1023]) begin
      failures++;
      $display("FAIL sweep_write_ignored got=%h exp=%h", bus.dataOut, ref_mem[1023]);
    end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    do_write(10'd7, 32'hCAFE_0007);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 100; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_sweep("mid_sweep");
    bus.address = 10'd7;
    #1;
    checks++;
    if (bus.dataOut !== '0) begin
      failures++;
      $display("FAIL mid_sweep_read got=%h exp=0", bus.dataOut);
    end
    step();
  endtask

  task automatic test_boundary();
    do_write(10'd1023, 32'hDEAD_BEEF);
    do_write(10'd0,    32'h1234_5678);
    bus.address = 10'd1023;
    #1;
    checks++;
    if (bus.dataOut !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL boundary_top got=%h exp=deadbeef", bus.dataOut);
    end
    bus.address = 10'd0;
    #1;
    checks++;
    if (bus.dataOut !== 32'h1234_5678) begin
      failures++;
      $display("FAIL boundary_bottom got=%h exp=12345678", bus.dataOut);
    end
    step();
    // write coincident with reset must be dropped
    bus.address = 10'd1023;
    bus.WR_RD   = 1'b0;
    bus.dataIn  = 32'h5555_AAAA;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_sweep("rst_write");
    bus.address = 10'd1023;
    #1;
    checks++;
    if (bus.dataOut !== '0) begin
      failures++;
      $display("FAIL rst_write_dropped got=%h exp=0", bus.dataOut);
    end
    step();
  endtask

  initial begin
    bus.address = '0;
    bus.WR_RD   = 1'b1;
    bus.dataIn  = '0;
    clear_model();
    #1;
    test_powerup();
    test_write_burst();
    test_async_read();
    test_random_traffic();
    test_reset_clear();
    test_random_traffic();
    test_reset_mid_sweep();
    test_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
